debug_button_events: RTL and testbench
======================================

# debug_button_events

Converts a debounced push-button level into single-cycle event pulses for the RISC-V debug front panel: press, release, short-click, long-press and auto-repeat, plus a wrapping press counter. It sits directly downstream of the switch debouncer, whose registered output drives `i_Switch`. Its pulses feed the debug controller for single-step, run/halt and step-repeat.

## Interface
- `ACTIVE_LOW`, 1: `i_Switch` level meaning "pressed" is 0 when set. Tang Nano buttons are active-low.
- `LONG_LIMIT`, 25_000_000: cycles from the press pulse to the long pulse (1 s at 25 MHz). Must be ≥ 2.
- `REPEAT_LIMIT`, 5_000_000: cycles between successive repeat pulses, and from the long pulse to the first repeat (200 ms). Must be ≥ 2.
- `CNT_W`, 25: hold counter width. Must satisfy 2^CNT_W > max(LONG_LIMIT, REPEAT_LIMIT).
- `i_Clk` input 1: system clock, rising edge.
- `i_Rst_n` input 1: reset, asynchronous assert, active-low.
- `i_Switch` input 1: debounced button level, already synchronous to `i_Clk`.
- `o_Pressed` output 1: registered normalized level (1 = held).
- `o_Press_Pulse` output 1: one-cycle pulse on press.
- `o_Release_Pulse` output 1: one-cycle pulse on every release.
- `o_Short_Pulse` output 1: one-cycle pulse on a release that occurs before the long threshold.
- `o_Long_Pulse` output 1: one-cycle pulse when the hold reaches `LONG_LIMIT`.
- `o_Repeat_Pulse` output 1: one-cycle pulse every `REPEAT_LIMIT` cycles while held after the long pulse.
- `o_Press_Count` output 8: number of presses, modulo 256.

## Operation
- Normalize the input: p = `i_Switch` XOR `ACTIVE_LOW`.
- State machine with three states:
  - IDLE: on p = 1, go to SHORT, clear the counter, fire the press pulse, and increment the press count.
  - SHORT: increment the counter each cycle.
    - On p = 0, fire the release and short pulses and go to IDLE.
    - Otherwise, when counter = LONG_LIMIT−1, fire the long pulse, clear the counter, and go to LONG_HELD.
  - LONG_HELD: increment the counter each cycle.
    - On p = 0, fire the release pulse only and go to IDLE.
    - Otherwise, when counter = REPEAT_LIMIT−1, fire the repeat pulse and clear the counter.
- Simultaneous release and limit hit in the same cycle: release wins. In SHORT this fires release + short with no long pulse. In LONG_HELD it fires release with no repeat pulse.
- At most one of press / long / repeat / release fires in a cycle. Short always coincides with release.
- `o_Press_Count` wraps 255 → 0 without a flag.
- Reset values: all outputs 0, state IDLE, counter 0.
- A button held through reset release produces a press pulse one cycle after the first rising edge at which reset is deasserted.
- Reset asserted mid-hold: all outputs clear immediately (asynchronous). No release or short pulse is emitted.

## Timing
- Latency: `i_Switch` is sampled at edge k, and the resulting pulse/level is visible after edge k, high for exactly one cycle. `o_Pressed` follows the normalized input with the same 1-cycle latency.
- The press pulse is in cycle c. The long pulse is in cycle c + LONG_LIMIT. Repeat pulses are in cycles c + LONG_LIMIT + n·REPEAT_LIMIT, for n ≥ 1.
- Hold of exactly LONG_LIMIT−1 cycles: release is seen in the cycle where the counter would reach LONG_LIMIT−1. The result is short, not long.
- Minimum press: a 1-cycle high on p gives press in cycle c, then release + short in cycle c+1.
- No handshake. Consumers must sample every cycle. Outputs are all registered, with no combinational path from `i_Switch`.

## Structure
- Shared package `debug_input_pkg`:
  - state encoding IDLE = 2'd0, SHORT = 2'd1, LONG_HELD = 2'd2;
  - default timing constants for 25 MHz.
  - The debouncer limit and these defaults live together there.
- One natural sub-module, `hold_timer`:
  - a CNT_W-bit counter with clear, enable, and a terminal-count compare against a run-time selected limit;
  - the state machine selects LONG_LIMIT or REPEAT_LIMIT.
- Encoding 2'd3 is illegal and recovers to IDLE.

## Test plan
All scenarios use ACTIVE_LOW = 1, LONG_LIMIT = 8, REPEAT_LIMIT = 4.
- Short click: `i_Switch` low for 3 cycles, then high.
  - Press at c; release + short at c+3.
  - `o_Press_Count` = 1; no long pulse.
- Long hold: `i_Switch` low for 20 cycles.
  - Press at c; long at c+8; repeats at c+12 and c+16.
  - Release only at c+20; no short pulse.
- Boundary: release timed to coincide with counter = 7.
  - Release + short fire; long never fires.
  - Repeat with release at the repeat boundary: no repeat pulse.
- Counter wrap: 256 short clicks give `o_Press_Count` = 0; the 257th gives 1.
- Reset mid-hold: assert `i_Rst_n` = 0 while in LONG_HELD.
  - All outputs are 0 asynchronously.
  - Deassert with the button still held: press pulse 1 cycle later, count = 1.
- Polarity: ACTIVE_LOW = 0 with `i_Switch` high for 2 cycles gives press, then release + short.

Source files
------------

// File: rtl/debug_input_pkg.sv
// ============================================================================
// debug_input_pkg : shared front-panel input types and 25 MHz timing defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package debug_input_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHORT     = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    // Debouncer settle time lives here so all front-panel timing is in one place.
    localparam int DEF_DEBOUNCE_LIMIT = 250_000;
    localparam int DEF_LONG_LIMIT     = 25_000_000;
    localparam int DEF_REPEAT_LIMIT   = 5_000_000;
    localparam int DEF_CNT_W          = 25;

endpackage

`default_nettype wire

// File: rtl/hold_timer.sv
// ============================================================================
// hold_timer : hold-duration counter with terminal-count compare
// Rev 1.0
// ============================================================================
`default_nettype none

module hold_timer #(
    parameter int CNT_W = 25
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Clear,
    input  logic             i_Enable,
    input  logic [CNT_W-1:0] i_Limit,
    output logic             o_Terminal
);

    logic [CNT_W-1:0] r_Count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Count <= '0;
        end else if (i_Clear) begin
            r_Count <= '0;
        end else if (i_Enable) begin
            r_Count <= r_Count + CNT_W'(1);
        end
    end

    // Terminal one count early so the event lands exactly LIMIT cycles after the clear.
    assign o_Terminal = (r_Count == (i_Limit - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/debug_button_events.sv
// ============================================================================
// debug_button_events : debounced button level -> press/release/short/long/
//                       repeat pulses and a wrapping press counter
// Rev 1.0
// ============================================================================
`default_nettype none

module debug_button_events
    import debug_input_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int LONG_LIMIT   = DEF_LONG_LIMIT,
    parameter int REPEAT_LIMIT = DEF_REPEAT_LIMIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch,
    output logic       o_Pressed,
    output logic       o_Press_Pulse,
    output logic       o_Release_Pulse,
    output logic       o_Short_Pulse,
    output logic       o_Long_Pulse,
    output logic       o_Repeat_Pulse,
    output logic [7:0] o_Press_Count
);

    btn_state_t       r_State;
    logic             r_Pressed;
    logic             r_Press;
    logic             r_Release;
    logic             r_Short;
    logic             r_Long;
    logic             r_Repeat;
    logic [7:0]       r_Press_Count;

    logic             w_P;
    logic             w_Held;
    logic             w_Term;
    logic             w_Clear;
    logic [CNT_W-1:0] w_Limit;

    assign w_P     = i_Switch ^ ACTIVE_LOW;
    assign w_Held  = (r_State == SHORT) || (r_State == LONG_HELD);
    assign w_Limit = (r_State == LONG_HELD) ? CNT_W'(REPEAT_LIMIT) : CNT_W'(LONG_LIMIT);
    // Counter restarts on entry to a hold and after every long/repeat event.
    assign w_Clear = !w_Held || (w_P && w_Term);

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Clear    (w_Clear),
        .i_Enable   (w_Held),
        .i_Limit    (w_Limit),
        .o_Terminal (w_Term)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State       <= IDLE;
            r_Pressed     <= 1'b0;
            r_Press       <= 1'b0;
            r_Release     <= 1'b0;
            r_Short       <= 1'b0;
            r_Long        <= 1'b0;
            r_Repeat      <= 1'b0;
            r_Press_Count <= 8'd0;
        end else begin
            r_Pressed <= w_P;
            r_Press   <= 1'b0;
            r_Release <= 1'b0;
            r_Short   <= 1'b0;
            r_Long    <= 1'b0;
            r_Repeat  <= 1'b0;
            // Release is tested before the terminal count so it wins a tie.
            case (r_State)
                IDLE: begin
                    if (w_P) begin
                        r_State       <= SHORT;
                        r_Press       <= 1'b1;
                        r_Press_Count <= r_Press_Count + 8'd1;
                    end
                end
                SHORT: begin
                    if (!w_P) begin
                        r_State   <= IDLE;
                        r_Release <= 1'b1;
                        r_Short   <= 1'b1;
                    end else if (w_Term) begin
                        r_State <= LONG_HELD;
                        r_Long  <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!w_P) begin
                        r_State   <= IDLE;
                        r_Release <= 1'b1;
                    end else if (w_Term) begin
                        r_Repeat <= 1'b1;
                    end
                end
                default: r_State <= IDLE;
            endcase
        end
    end

    assign o_Pressed       = r_Pressed;
    assign o_Press_Pulse   = r_Press;
    assign o_Release_Pulse = r_Release;
    assign o_Short_Pulse   = r_Short;
    assign o_Long_Pulse    = r_Long;
    assign o_Repeat_Pulse  = r_Repeat;
    assign o_Press_Count   = r_Press_Count;

endmodule

`default_nettype wire

// File: tb/tb_debug_button_events.sv
// ============================================================================
// tb_debug_button_events : two instances (active-low / active-high) against a
//                          hold-time reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_debug_button_events;

    localparam int LL = 8;
    localparam int RL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw0;
    logic       sw1;
    logic [1:0] pr, pp, rp, sp, lp, tp;
    logic [7:0] pc0, pc1;

    always #5 clk = ~clk;

    debug_button_events #(
        .ACTIVE_LOW (1'b1), .LONG_LIMIT (LL), .REPEAT_LIMIT (RL), .CNT_W (4)
    ) dut0 (
        .i_Clk (clk), .i_Rst_n (rst_n), .i_Switch (sw0),
        .o_Pressed (pr[0]), .o_Press_Pulse (pp[0]), .o_Release_Pulse (rp[0]),
        .o_Short_Pulse (sp[0]), .o_Long_Pulse (lp[0]), .o_Repeat_Pulse (tp[0]),
        .o_Press_Count (pc0)
    );

    debug_button_events #(
        .ACTIVE_LOW (1'b0), .LONG_LIMIT (LL), .REPEAT_LIMIT (RL), .CNT_W (4)
    ) dut1 (
        .i_Clk (clk), .i_Rst_n (rst_n), .i_Switch (sw1),
        .o_Pressed (pr[1]), .o_Press_Pulse (pp[1]), .o_Release_Pulse (rp[1]),
        .o_Short_Pulse (sp[1]), .o_Long_Pulse (lp[1]), .o_Repeat_Pulse (tp[1]),
        .o_Press_Count (pc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: time since press in cycles decides every event.
    bit m_held[2];
    int m_t[2];
    int m_cnt[2];
    bit e_pr[2], e_press[2], e_rel[2], e_short[2], e_long[2], e_rep[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_held[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
            e_pr[i] = 0; e_press[i] = 0; e_rel[i] = 0;
            e_short[i] = 0; e_long[i] = 0; e_rep[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit p);
        e_pr[i] = p; e_press[i] = 0; e_rel[i] = 0;
        e_short[i] = 0; e_long[i] = 0; e_rep[i] = 0;
        if (!m_held[i]) begin
            if (p) begin
                e_press[i] = 1;
                m_held[i]  = 1;
                m_t[i]     = 0;
                m_cnt[i]   = (m_cnt[i] + 1) % 256;
            end
        end else begin
            m_t[i]++;
            if (!p) begin
                e_rel[i]   = 1;
                e_short[i] = (m_t[i] <= LL);
                m_held[i]  = 0;
            end else if (m_t[i] == LL) begin
                e_long[i] = 1;
            end else if (m_t[i] > LL && ((m_t[i] - LL) % RL) == 0) begin
                e_rep[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_pressed", i), 32'(pr[i]), 32'(e_pr[i]));
            check($sformatf("d%0d_press", i),   32'(pp[i]), 32'(e_press[i]));
            check($sformatf("d%0d_release", i), 32'(rp[i]), 32'(e_rel[i]));
            check($sformatf("d%0d_short", i),   32'(sp[i]), 32'(e_short[i]));
            check($sformatf("d%0d_long", i),    32'(lp[i]), 32'(e_long[i]));
            check($sformatf("d%0d_repeat", i),  32'(tp[i]), 32'(e_rep[i]));
        end
        check("d0_count", 32'(pc0), 32'(m_cnt[0]));
        check("d1_count", 32'(pc1), 32'(m_cnt[1]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs0"}, {26'd0, pr[0], pp[0], rp[0], sp[0], lp[0], tp[0]}, 32'd0);
        check({tag, "_outs1"}, {26'd0, pr[1], pp[1], rp[1], sp[1], lp[1], tp[1]}, 32'd0);
        check({tag, "_cnt0"}, 32'(pc0), 32'd0);
        check({tag, "_cnt1"}, 32'(pc1), 32'd0);
    endtask

    // p0/p1 are normalized "pressed" levels for the two instances.
    task automatic step(input bit p0, input bit p1);
        sw0 = ~p0;
        sw1 = p1;
        @(posedge clk);
        model_edge(0, p0);
        model_edge(1, p1);
        #1;
        compare_all();
    endtask

    task automatic hold0(input int n);
        repeat (n) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    int run0, run1;
    bit lv0, lv1;

    initial begin
        rst_n = 1'b0;
        sw0   = 1'b1;
        sw1   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        hold0(3);             // short click
        hold0(20);            // long hold with repeats, release at repeat boundary
        hold0(LL - 1);        // hold of LONG_LIMIT-1 cycles
        hold0(LL);            // release coincides with long terminal count
        hold0(LL + RL);       // release coincides with first repeat
        hold0(1);             // minimum press

        step(1'b0, 1'b1);     // active-high instance
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset while in LONG_HELD with the button still held.
        repeat (LL + 2) step(1'b1, 1'b0);
        sw0 = 1'b0;
        pulse_reset();
        step(1'b1, 1'b0);
        check("rst_hold_press", 32'(pp[0]), 32'd1);
        check("rst_hold_count", 32'(pc0), 32'd1);
        step(1'b0, 1'b0);

        // Press counter wrap from a clean reset.
        sw0 = 1'b1;
        pulse_reset();
        repeat (256) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check("wrap_256", 32'(pc0), 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("wrap_257", 32'(pc0), 32'd1);

        // Independent random run lengths on both instances.
        lv0 = 0; lv1 = 0;
        run0 = 1; run1 = 1;
        repeat (2000) begin
            run0--;
            if (run0 == 0) begin
                lv0  = ~lv0;
                run0 = lv0 ? int'($urandom_range(1, 22)) : int'($urandom_range(1, 4));
            end
            run1--;
            if (run1 == 0) begin
                lv1  = ~lv1;
                run1 = lv1 ? int'($urandom_range(1, 22)) : int'($urandom_range(1, 4));
            end
            step(lv0, lv1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
